// File: rtl/ulpb_lc_rx_ctrl_pkg.sv
// Shared widths, FSM encoding and helpers for the ULPB layer-controller RX path.
package ulpb_lc_rx_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH        = 8;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned LC_REG_ADDR_WIDTH = 8;
  localparam int unsigned LC_REG_DATA_WIDTH = 24;
  localparam int unsigned LC_FUNC_WIDTH     = 4;
  localparam int unsigned CNT_WIDTH         = 8;

  // StAckHold returns to idle; StDiscAck returns to idle or keeps discarding.
  typedef enum logic [1:0] {
    StIdle,
    StAckHold,
    StDiscard,
    StDiscAck
  } rx_state_e;

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/ulpb_lc_rx_ctrl_if.sv
// Wrapper-side RX handshake, register-file write port and status outputs.
interface ulpb_lc_rx_ctrl_if;
  import ulpb_lc_rx_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0]        RX_ADDR;
  logic [DATA_WIDTH-1:0]        RX_DATA;
  logic                         RX_REQ;
  logic                         RX_PEND;
  logic                         RX_FAIL;
  logic                         RX_ACK;
  logic                         REG_WR_EN;
  logic [LC_REG_ADDR_WIDTH-1:0] REG_WR_ADDR;
  logic [LC_REG_DATA_WIDTH-1:0] REG_WR_DATA;
  logic                         REG_WR_READY;
  logic                         OVF;
  logic [CNT_WIDTH-1:0]         MSG_CNT;
  logic [CNT_WIDTH-1:0]         DROP_CNT;

  // Wrapper / register-file side.
  modport master (
    output RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, REG_WR_READY,
    input  RX_ACK, REG_WR_EN, REG_WR_ADDR, REG_WR_DATA, OVF, MSG_CNT, DROP_CNT
  );

  // Layer controller side.
  modport slave (
    input  RX_ADDR, RX_DATA, RX_REQ, RX_PEND, RX_FAIL, REG_WR_READY,
    output RX_ACK, REG_WR_EN, REG_WR_ADDR, REG_WR_DATA, OVF, MSG_CNT, DROP_CNT
  );

endinterface

// File: rtl/ulpb_lc_rx_fifo.sv
// Commit/rollback FIFO: words are pushed uncommitted, become visible to the
// reader only on commit, and vanish on rollback.
module ulpb_lc_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             commit,
  input  logic             rollback,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic [PTR_W:0]   ucount,
  output logic [PTR_W:0]   ccount
);

  typedef logic [PTR_W:0] ptr_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t cm_ptr_q, cm_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;

  assign ucount = wr_ptr_q - cm_ptr_q;
  assign ccount = cm_ptr_q - rd_ptr_q;
  assign full   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata  = mem[rd_ptr_q[PTR_W-1:0]];

  // Pointer next-state; rollback overrides push, commit covers the word pushed this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (rollback) begin
      wr_ptr_d = cm_ptr_q;
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (commit && !rollback) begin
      cm_ptr_d = wr_ptr_d;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until committed, so no reset.
  always_ff @(posedge clk) begin
    if (push && !rollback) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ulpb_lc_rx_ctrl.sv
// ULPB layer-controller RX path: acknowledges wrapper words, filters by
// function ID, buffers whole messages and drains them into the register file.
// Optional statistics counters are built when ULPB_LC_RX_STATS_EN is defined.
module ulpb_lc_rx_ctrl
  import ulpb_lc_rx_ctrl_pkg::*;
#(
  parameter logic [LC_FUNC_WIDTH-1:0] FUNC_ID = 4'h1,
  parameter int unsigned              DEPTH   = 4,
  parameter int unsigned              PTR_W   = 2
) (
  input  logic               CLKIN,
  input  logic               RESET,
  ulpb_lc_rx_ctrl_if.slave   bus
);

  typedef logic [PTR_W:0] ptr_t;

  rx_state_e state_q, state_d;
  logic      last_q, last_d;   // discard ends after the current ack
  logic      fail_q;
  logic      ovf_q;

  logic      rx_ack;
  logic      new_req, hit, fail_rise;
  logic      push, commit, rollback, set_ovf, drop;
  logic      wr_en;
  logic      full;
  ptr_t      ucount, ccount;
  logic [DATA_WIDTH-1:0] head;

  assign new_req   = bus.RX_REQ && !rx_ack;
  assign hit       = (bus.RX_ADDR[LC_FUNC_WIDTH-1:0] == FUNC_ID);
  assign fail_rise = bus.RX_FAIL && !fail_q;

  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.RX_ADDR[ADDR_WIDTH-1:LC_FUNC_WIDTH];

  // FSM state register.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // FSM next state plus FIFO control; a failing bus wins over any new word.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    push     = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    set_ovf  = 1'b0;
    drop     = 1'b0;
    if (fail_rise) begin
      rollback = 1'b1;
      drop     = 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (new_req) begin
          if (fail_rise) begin
            state_d = StDiscAck;
            last_d  = 1'b1;
          end else if (!hit) begin
            state_d = StDiscAck;
            last_d  = !bus.RX_PEND;
          end else if (ucount == ptr_t'(DEPTH)) begin
            // Message longer than the FIFO: discard everything already stored.
            rollback = 1'b1;
            set_ovf  = 1'b1;
            drop     = 1'b1;
            state_d  = StDiscAck;
            last_d   = !bus.RX_PEND;
          end else if (!full) begin
            push    = 1'b1;
            commit  = !bus.RX_PEND;
            state_d = StAckHold;
          end
          // Otherwise full with committed words: stall until the drain frees one.
        end
      end
      StAckHold: begin
        if (!bus.RX_REQ) begin
          state_d = StIdle;
        end
      end
      StDiscard: begin
        if (fail_rise) begin
          state_d = new_req ? StDiscAck : StIdle;
          last_d  = 1'b1;
        end else if (new_req) begin
          state_d = StDiscAck;
          last_d  = !bus.RX_PEND;
        end
      end
      StDiscAck: begin
        if (fail_rise) begin
          last_d = 1'b1;
        end
        if (!bus.RX_REQ) begin
          state_d = last_d ? StIdle : StDiscard;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: acknowledge is purely state-decoded, so it drops with RESET.
  always_comb begin
    rx_ack = (state_q == StAckHold) || (state_q == StDiscAck);
  end

  // Fail edge detector and sticky overflow flag.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      fail_q <= bus.RX_FAIL;
      ovf_q  <= ovf_q | set_ovf;
    end
  end

  ulpb_lc_rx_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk      (CLKIN),
    .rst      (RESET),
    .push     (push),
    .wdata    (bus.RX_DATA),
    .commit   (commit),
    .rollback (rollback),
    .pop      (wr_en),
    .rdata    (head),
    .full     (full),
    .ucount   (ucount),
    .ccount   (ccount)
  );

  // Drain one committed word per cycle whenever the register file is ready.
  always_comb begin
    wr_en = (ccount != '0) && bus.REG_WR_READY;
  end

  assign bus.RX_ACK      = rx_ack;
  assign bus.REG_WR_EN   = wr_en;
  assign bus.REG_WR_ADDR = wr_en ? head[DATA_WIDTH-1:LC_REG_DATA_WIDTH] : '0;
  assign bus.REG_WR_DATA = wr_en ? head[LC_REG_DATA_WIDTH-1:0] : '0;
  assign bus.OVF         = ovf_q;

`ifdef ULPB_LC_RX_STATS_EN
  logic [CNT_WIDTH-1:0] msg_cnt_q, drop_cnt_q;

  // Saturating committed / dropped message counters.
  always_ff @(posedge CLKIN or posedge RESET) begin
    if (RESET) begin
      msg_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit) msg_cnt_q <= sat_inc(msg_cnt_q);
      if (drop)   drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign bus.MSG_CNT  = msg_cnt_q;
  assign bus.DROP_CNT = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop  = drop;
  assign bus.MSG_CNT  = '0;
  assign bus.DROP_CNT = '0;
`endif

endmodule
